// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition trigger controller.
// A frame packs four 14-bit channels as {ch_d, ch_c, ch_b, ch_a}, with ch_a in the LSBs.
package acq_pkg;

  localparam int unsigned NCH      = 4;
  localparam int unsigned SAMPLE_W = 14;
  localparam int unsigned FRAME_W  = NCH * SAMPLE_W;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StArmed,
    StPost,
    StDone
  } acq_state_e;

  // Channel idx of a packed frame; idx 0 is ch_a.
  function automatic logic [SAMPLE_W-1:0] frame_ch(input logic [FRAME_W-1:0] frame,
                                                   input int unsigned idx);
    return frame[idx*SAMPLE_W +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/acq_mag_cmp.sv
// Per-channel trigger comparator: saturating magnitude of a two's-complement sample
// compared against an unsigned threshold, gated by the channel enable.
module acq_mag_cmp
  import acq_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [SAMPLE_W-1:0] threshold_i,
  input  logic                en_i,
  output logic                hit_o
);

  localparam logic [SAMPLE_W-1:0] MostNeg = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MaxMag  = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] mag;

  // The most negative code has no positive twin, so it saturates.
  always_comb begin
    if (sample_i == MostNeg) begin
      mag = MaxMag;
    end else if (sample_i[SAMPLE_W-1]) begin
      mag = ~sample_i + 1'b1;
    end else begin
      mag = sample_i;
    end
  end

  assign hit_o = en_i && (mag >= threshold_i);

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: fills a circular sample buffer, triggers on channel magnitude and
// stops after the post-trigger count. Define ACQ_TRIG_TIMEOUT_EN for the forced-trigger timeout.
module acq_trigger_ctrl
  import acq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned PRE_TRIG = 1024
`ifdef ACQ_TRIG_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT  = 65535
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_vld,
  input  logic [FRAME_W-1:0] samples,
  input  logic               arm,
  input  logic               abort,
  input  logic               ack,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic [NCH-1:0]     ch_en,
  output logic               buf_we,
  output logic [ADDR_W-1:0]  buf_waddr,
  output logic [FRAME_W-1:0] buf_wdata,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  start_addr,
  output logic [ADDR_W-1:0]  trig_addr,
  output logic [NCH-1:0]     trig_ch
`ifdef ACQ_TRIG_TIMEOUT_EN
  ,
  output logic               timed_out
`endif
);

  localparam int unsigned DEPTH    = 32'd1 << ADDR_W;
  localparam int unsigned POST_LEN = DEPTH - PRE_TRIG;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  PreCnt  = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  PostCnt = CNT_W'(POST_LEN);
  localparam logic [ADDR_W-1:0] PreAddr = ADDR_W'(PRE_TRIG);

  acq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               buf_we_q, buf_we_d;
  logic [ADDR_W-1:0]  buf_waddr_q, buf_waddr_d;
  logic [FRAME_W-1:0] buf_wdata_q, buf_wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  start_addr_q, start_addr_d;
  logic [ADDR_W-1:0]  trig_addr_q, trig_addr_d;
  logic [NCH-1:0]     trig_ch_q, trig_ch_d;
  logic [NCH-1:0]     hits;
  logic               trig;
  logic               forced;
  logic               wr;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    acq_mag_cmp u_cmp (
      .sample_i    (frame_ch(samples, c)),
      .threshold_i (threshold),
      .en_i        (ch_en[c]),
      .hit_o       (hits[c])
    );
  end

  assign trig    = |hits;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef ACQ_TRIG_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timed_out_q, timed_out_d;

  // Fires on the frame that would bring the ARMED frame count up to TIMEOUT.
  assign forced    = (to_cnt_q + 16'd1) == TimeoutCnt;
  assign timed_out = timed_out_q;
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    wr           = 1'b0;
    buf_we_d     = 1'b0;
    buf_waddr_d  = buf_waddr_q;
    buf_wdata_d  = buf_wdata_q;
    done_d       = done_q;
    start_addr_d = start_addr_q;
    trig_addr_d  = trig_addr_q;
    trig_ch_d    = trig_ch_q;
`ifdef ACQ_TRIG_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timed_out_d  = timed_out_q;
`endif

    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
`ifdef ACQ_TRIG_TIMEOUT_EN
      timed_out_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            state_d   = (PRE_TRIG == 0) ? StArmed : StFill;
            done_d    = 1'b0;
            cnt_d     = '0;
            trig_ch_d = '0;
            ptr_d     = '0;
`ifdef ACQ_TRIG_TIMEOUT_EN
            to_cnt_d    = '0;
            timed_out_d = 1'b0;
`endif
          end else if (ack) begin
            state_d = StIdle;
            done_d  = 1'b0;
`ifdef ACQ_TRIG_TIMEOUT_EN
            timed_out_d = 1'b0;
`endif
          end
        end
        StFill: begin
          if (sample_vld) begin
            wr    = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == PreCnt) begin
              state_d = StArmed;
`ifdef ACQ_TRIG_TIMEOUT_EN
              to_cnt_d = '0;
`endif
            end
          end
        end
        StArmed: begin
          if (sample_vld) begin
            wr = 1'b1;
`ifdef ACQ_TRIG_TIMEOUT_EN
            to_cnt_d = to_cnt_q + 16'd1;
`endif
            if (trig || forced) begin
              trig_addr_d  = ptr_q;
              start_addr_d = ptr_q - PreAddr;
              trig_ch_d    = hits;
              // The trigger frame is the first of the post-trigger frames.
              cnt_d        = CNT_W'(1);
              state_d      = (PostCnt == CNT_W'(1)) ? StDone : StPost;
              done_d       = (PostCnt == CNT_W'(1));
`ifdef ACQ_TRIG_TIMEOUT_EN
              timed_out_d  = !trig;
`endif
            end
          end
        end
        StPost: begin
          if (sample_vld) begin
            wr    = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == PostCnt) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (wr) begin
      buf_we_d    = 1'b1;
      buf_waddr_d = ptr_q;
      buf_wdata_d = samples;
      ptr_d       = ptr_q + 1'b1;
    end

    busy_d = (state_d == StFill) || (state_d == StArmed) || (state_d == StPost);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      buf_we_q     <= 1'b0;
      buf_waddr_q  <= '0;
      buf_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_addr_q <= '0;
      trig_addr_q  <= '0;
      trig_ch_q    <= '0;
`ifdef ACQ_TRIG_TIMEOUT_EN
      to_cnt_q     <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      buf_we_q     <= buf_we_d;
      buf_waddr_q  <= buf_waddr_d;
      buf_wdata_q  <= buf_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_addr_q <= start_addr_d;
      trig_addr_q  <= trig_addr_d;
      trig_ch_q    <= trig_ch_d;
`ifdef ACQ_TRIG_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

  assign buf_we     = buf_we_q;
  assign buf_waddr  = buf_waddr_q;
  assign buf_wdata  = buf_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign start_addr = start_addr_q;
  assign trig_addr  = trig_addr_q;
  assign trig_ch    = trig_ch_q;

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Bench for acq_trigger_ctrl with a 16-frame buffer and 4 pre-trigger frames; expected
// writes and trigger results come from a frame-list model of the capture rules.
module tb_acq_trigger_ctrl;

  localparam int AW    = 4;
  localparam int PT    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int POSTN = DEPTH - PT;
  localparam int TO    = 8;

  logic        clk = 1'b0;
  logic        rst, sample_vld, arm, abort, ack;
  logic [55:0] samples;
  logic [13:0] threshold;
  logic [3:0]  ch_en;
  logic        buf_we, busy, done;
  logic [AW-1:0] buf_waddr, start_addr, trig_addr;
  logic [55:0] buf_wdata;
  logic [3:0]  trig_ch;
`ifdef ACQ_TRIG_TIMEOUT_EN
  logic        timed_out;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acq_trigger_ctrl #(
    .ADDR_W   (AW),
    .PRE_TRIG (PT)
`ifdef ACQ_TRIG_TIMEOUT_EN
    ,
    .TIMEOUT  (TO)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_vld (sample_vld),
    .samples    (samples),
    .arm        (arm),
    .abort      (abort),
    .ack        (ack),
    .threshold  (threshold),
    .ch_en      (ch_en),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .busy       (busy),
    .done       (done),
    .start_addr (start_addr),
    .trig_addr  (trig_addr),
    .trig_ch    (trig_ch)
`ifdef ACQ_TRIG_TIMEOUT_EN
    ,
    .timed_out  (timed_out)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [55:0]   d;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk) if (buf_we) wq.push_back({buf_waddr, buf_wdata});

  // ---------------- reference model ----------------
  function automatic int mag_of(input logic [13:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 8191) v = 8191;
    return v;
  endfunction

  function automatic logic [3:0] hits_of(input logic [55:0] f, input int thr,
                                         input logic [3:0] en);
    logic [3:0] h;
    for (int c = 0; c < 4; c++) h[c] = en[c] && (mag_of(f[c*14 +: 14]) >= thr);
    return h;
  endfunction

  // Index of the trigger frame within the frames delivered after arm, or -1.
  function automatic int model_trig(input logic [55:0] fr[$], input int thr,
                                    input logic [3:0] en);
    for (int i = PT; i < fr.size(); i++) begin
      if (hits_of(fr[i], thr, en) != 4'b0) return i;
`ifdef ACQ_TRIG_TIMEOUT_EN
      if (i - PT + 1 == TO) return i;
`endif
    end
    return -1;
  endfunction

  function automatic logic [55:0] mkf(input int a, input int b, input int c, input int d);
    return {14'(d), 14'(c), 14'(b), 14'(a)};
  endfunction

  function automatic logic [55:0] rnd_frame(input int lim, input int big_pct);
    logic [55:0] f;
    int v;
    for (int c = 0; c < 4; c++) begin
      if (int'($urandom_range(0, 99)) < big_pct) v = int'($urandom_range(0, 16383)) - 8192;
      else v = int'($urandom_range(0, 2 * lim)) - lim;
      f[c*14 +: 14] = 14'(v);
    end
    return f;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [55:0] f);
    samples    = f;
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL reset_buf_we got %0b want 0", buf_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (buf_waddr !== '0) begin errors++; $display("FAIL reset_waddr got %0h want 0", buf_waddr); end
    checks++; if (buf_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %0h want 0", buf_wdata); end
    checks++; if (start_addr !== '0) begin errors++; $display("FAIL reset_start got %0h want 0", start_addr); end
    checks++; if (trig_addr !== '0) begin errors++; $display("FAIL reset_trig_addr got %0h want 0", trig_addr); end
    checks++; if (trig_ch !== 4'b0) begin errors++; $display("FAIL reset_trig_ch got %0b want 0", trig_ch); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_plan_capture();
    logic [55:0] fr[$];
    do_abort();
    wq.delete();
    threshold = 14'd100;
    ch_en     = 4'b1111;
    for (int i = 0; i < 10; i++) fr.push_back(rnd_frame(99, 0));
    fr.push_back(mkf(int'($urandom_range(0, 198)) - 99, -200, 5, -7));
    for (int i = 0; i < POSTN - 1; i++) fr.push_back(rnd_frame(8000, 20));
    do_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL plan_busy_after_arm got %0b want 1", busy); end
    for (int i = 0; i < fr.size(); i++) begin
      samples = fr[i];
      sample_vld = 1'b1;
      tick();
      sample_vld = 1'b0;
      checks++; if (buf_we !== 1'b1) begin errors++; $display("FAIL plan_we[%0d] got %0b want 1", i, buf_we); end
      checks++;
      if (done !== (i == fr.size() - 1)) begin
        errors++; $display("FAIL plan_done[%0d] got %0b want %0b", i, done, i == fr.size() - 1);
      end
      tick();
    end
    checks++; if (wq.size() != fr.size()) begin errors++; $display("FAIL plan_nwrites got %0d want %0d", wq.size(), fr.size()); end
    for (int i = 0; i < wq.size() && i < fr.size(); i++) begin
      checks++;
      if (wq[i].a !== AW'(i % DEPTH) || wq[i].d !== fr[i]) begin
        errors++;
        $display("FAIL plan_write[%0d] got %0d/%0h want %0d/%0h", i, wq[i].a, wq[i].d, i % DEPTH, fr[i]);
      end
    end
    checks++; if (trig_addr !== AW'(10)) begin errors++; $display("FAIL plan_trig_addr got %0d want 10", trig_addr); end
    checks++; if (trig_ch !== 4'b0010) begin errors++; $display("FAIL plan_trig_ch got %0b want 0010", trig_ch); end
    checks++; if (start_addr !== AW'(6)) begin errors++; $display("FAIL plan_start got %0d want 6", start_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL plan_busy_done got %0b want 0", busy); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL plan_done_held got %0b want 1", done); end
  endtask

  task automatic test_magnitude();
    // -8192 saturates to 8191 and meets threshold 8191
    do_abort();
    threshold = 14'd8191;
    ch_en     = 4'b0001;
    do_arm();
    for (int i = 0; i < PT; i++) send(mkf(0, 0, 0, 0));
    send(mkf(-8192, 0, 0, 0));
    checks++; if (trig_addr !== AW'(4)) begin errors++; $display("FAIL mag_neg_trig_addr got %0d want 4", trig_addr); end
    checks++; if (trig_ch !== 4'b0001) begin errors++; $display("FAIL mag_neg_trig_ch got %0b want 0001", trig_ch); end
    // 8190 is just below, 8191 just meets
    do_abort();
    do_arm();
    for (int i = 0; i < PT; i++) send(mkf(0, 0, 0, 0));
    send(mkf(8190, 8191, -8192, 8191));
    checks++; if (trig_ch !== 4'b0) begin errors++; $display("FAIL mag_below_trig_ch got %0b want 0", trig_ch); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mag_below_busy got %0b want 1", busy); end
    send(mkf(8191, 0, 0, 0));
    checks++; if (trig_addr !== AW'(5)) begin errors++; $display("FAIL mag_edge_trig_addr got %0d want 5", trig_addr); end
    checks++; if (trig_ch !== 4'b0001) begin errors++; $display("FAIL mag_edge_trig_ch got %0b want 0001", trig_ch); end
    // threshold 0 triggers on the first ARMED frame
    do_abort();
    threshold = 14'd0;
    ch_en     = 4'b1000;
    do_arm();
    for (int i = 0; i < PT; i++) send(mkf(0, 0, 0, 0));
    checks++; if (trig_ch !== 4'b0) begin errors++; $display("FAIL mag_thr0_fill got %0b want 0", trig_ch); end
    send(mkf(0, 0, 0, 0));
    checks++; if (trig_addr !== AW'(4)) begin errors++; $display("FAIL mag_thr0_trig_addr got %0d want 4", trig_addr); end
    checks++; if (trig_ch !== 4'b1000) begin errors++; $display("FAIL mag_thr0_trig_ch got %0b want 1000", trig_ch); end
    // no enabled channel never triggers
    do_abort();
    wq.delete();
    ch_en = 4'b0000;
    do_arm();
    for (int i = 0; i < PT + 7; i++) send(mkf(-8192, 8191, -8192, 8191));
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mag_noen_state got busy=%0b done=%0b want 1/0", busy, done); end
    checks++; if (trig_ch !== 4'b0) begin errors++; $display("FAIL mag_noen_trig_ch got %0b want 0", trig_ch); end
    checks++; if (wq.size() != PT + 7) begin errors++; $display("FAIL mag_noen_nwrites got %0d want %0d", wq.size(), PT + 7); end
  endtask

  task automatic test_fill_ignore();
    do_abort();
    threshold = 14'd100;
    ch_en     = 4'b1111;
    do_arm();
    send(mkf(3, 0, 0, 0));
    send(mkf(-5, 0, 0, 0));
    send(mkf(5000, 0, -3000, 0));
    checks++; if (trig_ch !== 4'b0) begin errors++; $display("FAIL fill_early_trig_ch got %0b want 0", trig_ch); end
    send(mkf(0, 0, 0, 0));
    send(mkf(20, -20, 0, 0));
    checks++; if (busy !== 1'b1 || trig_ch !== 4'b0) begin errors++; $display("FAIL fill_armed_quiet got busy=%0b trig_ch=%0b want 1/0", busy, trig_ch); end
    send(mkf(0, 0, 0, -101));
    checks++; if (trig_addr !== AW'(5)) begin errors++; $display("FAIL fill_trig_addr got %0d want 5", trig_addr); end
    checks++; if (trig_ch !== 4'b1000) begin errors++; $display("FAIL fill_trig_ch got %0b want 1000", trig_ch); end
    checks++; if (start_addr !== AW'(1)) begin errors++; $display("FAIL fill_start got %0d want 1", start_addr); end
  endtask

  task automatic test_abort_and_busy_arm();
    int n;
    do_abort();
    wq.delete();
    threshold = 14'd100;
    ch_en     = 4'b1111;
    do_arm();
    send(mkf(0, 0, 0, 0));
    send(mkf(0, 0, 0, 0));
    do_arm();  // ignored in FILL
    send(mkf(0, 0, 0, 0));
    send(mkf(0, 0, 0, 0));
    send(mkf(0, 0, 300, 0));
    for (int i = 0; i < 3; i++) send(mkf(1, 2, 3, 4));
    do_arm();  // ignored in POST
    send(mkf(9, 9, 9, 9));
    checks++; if (trig_ch !== 4'b0100) begin errors++; $display("FAIL busyarm_trig_ch got %0b want 0100", trig_ch); end
    checks++; if (wq.size() != 9) begin errors++; $display("FAIL busyarm_nwrites got %0d want 9", wq.size()); end
    for (int i = 0; i < wq.size(); i++) begin
      checks++; if (wq[i].a !== AW'(i)) begin errors++; $display("FAIL busyarm_addr[%0d] got %0d want %0d", i, wq[i].a, i); end
    end
    samples    = mkf(7, 7, 7, 7);
    sample_vld = 1'b1;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    sample_vld = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || buf_we !== 1'b0) begin
      errors++; $display("FAIL abort_next got busy=%0b done=%0b we=%0b want 0/0/0", busy, done, buf_we);
    end
    tick();
    n = wq.size();
    for (int i = 0; i < 3; i++) send(mkf(0, 0, 0, 0));
    checks++; if (wq.size() != n) begin errors++; $display("FAIL abort_nowrite got %0d want %0d", wq.size(), n); end
    // synchronous reset mid-fill
    do_arm();
    send(mkf(0, 0, 0, 0));
    rst        = 1'b1;
    sample_vld = 1'b1;
    tick();
    rst        = 1'b0;
    sample_vld = 1'b0;
    checks++; if (busy !== 1'b0 || buf_we !== 1'b0) begin errors++; $display("FAIL rst_mid got busy=%0b we=%0b want 0/0", busy, buf_we); end
    tick();
  endtask

  task automatic test_ack_arm();
    int n;
    do_abort();
    wq.delete();
    threshold = 14'd100;
    ch_en     = 4'b1111;
    do_arm();
    for (int i = 0; i < DEPTH; i++) send((i == PT) ? mkf(0, 150, 0, 0) : mkf(1, 1, 1, 1));
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ackarm_done got done=%0b busy=%0b want 1/0", done, busy); end
    tick();
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ackarm_held got %0b want 1", done); end
    ack        = 1'b1;
    arm        = 1'b1;
    sample_vld = 1'b1;
    samples    = mkf(0, 0, 0, 0);
    tick();
    ack        = 1'b0;
    arm        = 1'b0;
    sample_vld = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ackarm_rearm got done=%0b busy=%0b want 0/1", done, busy); end
    checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL ackarm_coincident_we got %0b want 0", buf_we); end
    checks++; if (trig_ch !== 4'b0) begin errors++; $display("FAIL ackarm_trig_ch got %0b want 0", trig_ch); end
    tick();
    samples    = mkf(2, 2, 2, 2);
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
    checks++; if (buf_we !== 1'b1 || buf_waddr !== '0) begin errors++; $display("FAIL ackarm_ptr got we=%0b addr=%0d want 1/0", buf_we, buf_waddr); end
    tick();
    for (int i = 1; i < DEPTH; i++) send((i == PT) ? mkf(0, 0, 150, 0) : mkf(1, 1, 1, 1));
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ack_done2 got %0b want 1", done); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ack_idle got done=%0b busy=%0b want 0/0", done, busy); end
    n = wq.size();
    send(mkf(3, 3, 3, 3));
    checks++; if (wq.size() != n) begin errors++; $display("FAIL ack_idle_nowrite got %0d want %0d", wq.size(), n); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [55:0] fr[$];
      int k, last, thr;
      logic [3:0] en;
      do_abort();
      wq.delete();
      thr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(20, 400));
      en  = 4'($urandom_range(0, 15));
      threshold = 14'(thr);
      ch_en     = en;
      for (int i = 0; i < 60; i++) fr.push_back(rnd_frame(60, 3));
      k = model_trig(fr, thr, en);
      for (int i = 0; i < POSTN; i++) fr.push_back(rnd_frame(8000, 10));
      last = (k < 0) ? 59 : k + POSTN - 1;
      do_arm();
      for (int i = 0; i <= last; i++) begin
        samples    = fr[i];
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        checks++;
        if (buf_we !== 1'b1 || done !== (k >= 0 && i == last)) begin
          errors++;
          $display("FAIL rnd%0d_frame[%0d] got we=%0b done=%0b want 1/%0b", it, i, buf_we, done, k >= 0 && i == last);
        end
        tick();
      end
      checks++; if (wq.size() != last + 1) begin errors++; $display("FAIL rnd%0d_nwrites got %0d want %0d", it, wq.size(), last + 1); end
      for (int i = 0; i < wq.size() && i <= last; i++) begin
        checks++;
        if (wq[i].a !== AW'(i % DEPTH) || wq[i].d !== fr[i]) begin
          errors++;
          $display("FAIL rnd%0d_write[%0d] got %0d/%0h want %0d/%0h", it, i, wq[i].a, wq[i].d, i % DEPTH, fr[i]);
        end
      end
      if (k >= 0) begin
        checks++;
        if (trig_addr !== AW'(k % DEPTH) || start_addr !== AW'(((k - PT) % DEPTH + DEPTH) % DEPTH)) begin
          errors++;
          $display("FAIL rnd%0d_addrs got trig=%0d start=%0d want %0d/%0d", it, trig_addr, start_addr, k % DEPTH, ((k - PT) % DEPTH + DEPTH) % DEPTH);
        end
        checks++;
        if (trig_ch !== hits_of(fr[k], thr, en) || busy !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_trig_ch got %0b busy=%0b want %0b/0", it, trig_ch, busy, hits_of(fr[k], thr, en));
        end
`ifdef ACQ_TRIG_TIMEOUT_EN
        checks++;
        if (timed_out !== (hits_of(fr[k], thr, en) == 4'b0)) begin
          errors++; $display("FAIL rnd%0d_timed_out got %0b want %0b", it, timed_out, hits_of(fr[k], thr, en) == 4'b0);
        end
`endif
      end else begin
        checks++;
        if (busy !== 1'b1 || trig_ch !== 4'b0) begin
          errors++; $display("FAIL rnd%0d_notrig got busy=%0b trig_ch=%0b want 1/0", it, busy, trig_ch);
        end
      end
    end
  endtask

`ifdef ACQ_TRIG_TIMEOUT_EN
  task automatic test_timeout();
    do_abort();
    threshold = 14'd100;
    ch_en     = 4'b1111;
    do_arm();
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL to_clear_on_arm got %0b want 0", timed_out); end
    for (int i = 0; i < PT + TO - 1; i++) send(mkf(1, -1, 2, -2));
    checks++; if (busy !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL to_early got busy=%0b to=%0b want 1/0", busy, timed_out); end
    send(mkf(0, 0, 0, 0));
    checks++; if (timed_out !== 1'b1) begin errors++; $display("FAIL to_fire got %0b want 1", timed_out); end
    checks++; if (trig_addr !== AW'(PT + TO - 1) || trig_ch !== 4'b0) begin
      errors++; $display("FAIL to_trig got addr=%0d ch=%0b want %0d/0", trig_addr, trig_ch, PT + TO - 1);
    end
    do_abort();
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL to_abort got %0b want 0", timed_out); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    sample_vld = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;
    ack        = 1'b0;
    samples    = '0;
    threshold  = '0;
    ch_en      = '0;
    test_reset();
    test_plan_capture();
    test_magnitude();
    test_fill_ignore();
    test_abort_and_busy_arm();
    test_ack_arm();
    test_random();
`ifdef ACQ_TRIG_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
